moving_average_filter: RTL

//  Boxcar averager over the last 2**LOG2_DEPTH ADC samples, in a circular buffer with a running sum.

---
 rtl/moving_average_filter.sv | 85 ++++++++
 1 files changed

// File: rtl/moving_average_filter.sv
// Boxcar averager over the last 2**LOG2_DEPTH samples using a circular buffer and a running sum.
// Optional feature: define AVG_ROUNDING_EN for round-half-up averaging instead of truncation.
module moving_average_filter #(
    parameter int WIDTH      = 13,
    parameter int LOG2_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    input  logic             hold,
    output logic [WIDTH-1:0] avg_out,
    output logic             avg_valid,
    output logic             filled
);

    localparam int D     = 2 ** LOG2_DEPTH;
    localparam int SUM_W = WIDTH + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] D_CNT = {1'b1, {LOG2_DEPTH{1'b0}}};

    logic [WIDTH-1:0]      r_buf [D];
    logic [LOG2_DEPTH-1:0] r_ptr;
    logic [SUM_W-1:0]      r_sum;
    logic [LOG2_DEPTH:0]   r_count;
    logic                  r_filled;
    logic                  r_acc_d;
    logic [WIDTH-1:0]      r_avg;
    logic                  r_avg_valid;

    logic                  w_accept;
    logic [SUM_W-1:0]      w_sum_next;
    logic [LOG2_DEPTH:0]   w_count_inc;
    logic [WIDTH-1:0]      w_avg;

    // Strobe protocol: a sample is taken on any edge where sample_valid is high and
    // hold is low; there is no back-pressure, so a strobe during hold is simply lost.
    assign w_accept    = sample_valid & ~hold;
    assign w_sum_next  = r_sum + SUM_W'(sample) - SUM_W'(r_buf[r_ptr]);
    assign w_count_inc = r_count + (LOG2_DEPTH+1)'(1);

`ifdef AVG_ROUNDING_EN
    // One extra bit keeps sum + D/2 from wrapping; the quotient still fits in WIDTH bits.
    logic [SUM_W:0] w_sum_rnd;
    assign w_sum_rnd = {1'b0, r_sum} + ((SUM_W+1)'(1) << (LOG2_DEPTH - 1));
    assign w_avg     = WIDTH'(w_sum_rnd >> LOG2_DEPTH);
`else
    assign w_avg     = WIDTH'(r_sum >> LOG2_DEPTH);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                r_buf[i] <= '0;
            end
            r_ptr       <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_filled    <= 1'b0;
            r_acc_d     <= 1'b0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_acc_d     <= w_accept;
            r_avg_valid <= r_acc_d;
            // r_sum already holds the post-accept total here, giving two-clock latency.
            if (r_acc_d) begin
                r_avg <= w_avg;
            end
            if (w_accept) begin
                r_sum        <= w_sum_next;
                r_buf[r_ptr] <= sample;
                r_ptr        <= r_ptr + LOG2_DEPTH'(1);
                if (r_count != D_CNT) begin
                    r_count <= w_count_inc;
                end
                r_filled <= r_filled | (w_count_inc >= D_CNT);
            end
        end
    end

    assign avg_out   = r_avg;
    assign avg_valid = r_avg_valid;
    assign filled    = r_filled;

endmodule
